vram_arbiter: RTL
=================

# vram_arbiter

Single-port VRAM arbiter and clear engine on the pixel clock. It sits between the display data path, which reads the 12-bit image memory, and two write sources that share the same port: a host writer using a req/ack handshake and a built-in full-frame clear engine. Display reads have absolute priority so scan-out is never stalled. Host writes and clear writes are served round-robin in cycles the display leaves free.

## Interface
- AW, 15, VRAM address width
- DW, 12, VRAM word width (RGB 4:4:4)
- DEPTH, 30000, number of valid words (200x150 image); addresses >= DEPTH are out of range
- RD_LAT, 1, VRAM read latency in pclk cycles (1..3)

- pclk  in  1  pixel clock, sole clock
- rstn  in  1  asynchronous active-low reset
- disp_re  in  1  display read request for this cycle
- disp_addr  in  AW  display read address
- disp_rdata  out  DW  read data, direct pass-through of mem_dout
- disp_rvalid  out  1  high RD_LAT cycles after a granted disp_re
- wr_req  in  1  host write request, held until acked
- wr_addr  in  AW  host write address
- wr_data  in  DW  host write data
- wr_ack  out  1  one-cycle pulse; the host write completes in this cycle
- clr_start  in  1  pulse that starts a full-frame clear
- clr_color  in  DW  fill value, sampled on an accepted clr_start
- clr_busy  out  1  clear in progress
- clr_done  out  1  one-cycle pulse after the last clear write
- mem_en, mem_we  out  1 each  VRAM port enable and write enable
- mem_addr  out  AW  VRAM address
- mem_din  out  DW  VRAM write data
- mem_dout  in  DW  VRAM read data

## Operation
- Grant is decided combinationally each cycle with priority display > {host, clear}.
- disp_re=1: mem_en=1, mem_we=0, mem_addr=disp_addr. Host and clear are both stalled.
- disp_re=0 with one write source pending: that source is granted.
- disp_re=0 with both host and clear pending: the rr_ptr register selects the source. Host wins when rr_ptr=0. After each granted write, rr_ptr points to the other source.
- Host grant: mem_en=1, wr_ack=1, and mem_we=(wr_addr<DEPTH). An out-of-range write is acked and dropped.
- No grant: mem_en=0, mem_we=0. mem_addr and mem_din are don't-care.
- Clear FSM:
  - IDLE: clr_start=1 → FILL; latch clr_color; clr_cnt=0; clr_busy=1.
  - FILL: on each clear grant, write clr_cnt with the latched color and increment clr_cnt. When the write at clr_cnt=DEPTH-1 is granted → DONE.
  - DONE: clr_done=1 for one cycle, clr_busy=0 → IDLE.
- clr_start is ignored in FILL and DONE. clr_color is only sampled on an accepted start.
- disp_rvalid comes from an RD_LAT-deep shift register fed by disp_re. disp_rdata=mem_dout, unregistered.
- Host writes during a clear are legal. Order is set by arbitration, and the later write wins.

## Timing
- Reset values: rr_ptr=0, FSM=IDLE, clr_cnt=0, clr_busy=0, clr_done=0, rvalid pipeline=0.
- While rstn=0, mem_en, mem_we and wr_ack are forced to 0.
- Reset asserted mid-clear aborts the clear. No clr_done is issued, and after release the FSM is IDLE.
- Display read: request in cycle t, data valid with disp_rvalid=1 in cycle t+RD_LAT.
- Host write: wr_ack rises in the same cycle the write reaches the port. Minimum latency is 0 cycles. The requester may change wr_addr/wr_data in the cycle after ack. Back-to-back requests can be acked every free cycle.
- Clear duration is DEPTH granted cycles. With no contention, clr_busy is high for DEPTH+1 cycles (FILL plus DONE), and clr_done falls one cycle after the final write.
- The 15-bit clr_cnt never wraps, because it stops at DEPTH-1.

## Test plan
- Display only: disp_re=1 for 8 cycles at addresses 0..7, RD_LAT=1 → mem_we=0 throughout; disp_rvalid high in cycles 1..8; disp_rdata equals memory contents.
- Host versus display: wr_req with addr 100, data 12'hF00, while disp_re=1 for 5 cycles → wr_ack stays 0 for 5 cycles, then pulses once; VRAM[100]=12'hF00.
- Clear: clr_start with color 12'h0F0, no other traffic → clr_busy high for 30001 cycles; one clr_done pulse; all 30000 words equal 12'h0F0. A second clr_start in mid-fill is ignored.
- Round-robin: clear running, with wr_req held for 4 writes and disp_re=0 → host and clear writes alternate, host first after reset; the clear takes 30004 cycles.
- Out of range: wr_addr=30000 → wr_ack=1 with mem_we=0; no VRAM word changes.
- Reset mid-clear: rstn low at clr_cnt=500 → clr_busy=0, clr_done never pulses, mem_en=0 while in reset; a fresh clr_start after release works normally.

Source files
------------

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter with a built-in full-frame clear engine.
// Display reads always own the port; host writes and clear writes share
// the remaining cycles round-robin.
//
// Host handshake: wr_req/wr_addr/wr_data are held stable by the requester
// until wr_ack. wr_ack is a combinational one-cycle pulse raised in the very
// cycle the write is presented to the VRAM port, so the requester may move
// on to new address/data on the following cycle. Out-of-range writes are
// acked but never reach the memory (mem_we stays low).
module vram_arbiter #(
    parameter int AW     = 15,
    parameter int DW     = 12,
    parameter int DEPTH  = 30000,
    parameter int RD_LAT = 1
) (
    input  logic          pclk,
    input  logic          rstn,
    input  logic          disp_re,
    input  logic [AW-1:0] disp_addr,
    output logic [DW-1:0] disp_rdata,
    output logic          disp_rvalid,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    output logic          wr_ack,
    input  logic          clr_start,
    input  logic [DW-1:0] clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    typedef enum logic [1:0] {
        CLR_IDLE = 2'd0,
        CLR_FILL = 2'd1,
        CLR_DONE = 2'd2
    } clr_state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W   = (AW + 1)'(DEPTH);

    clr_state_t    clr_state_q, clr_state_d;
    logic [AW-1:0] clr_cnt_q, clr_cnt_d;
    logic [DW-1:0] clr_col_q, clr_col_d;
    logic          rr_ptr_q, rr_ptr_d;   // 0: host wins a tie, 1: clear wins a tie
    logic [RD_LAT-1:0] rv_q;

    logic host_pend;
    logic clr_pend;
    logic gnt_host;
    logic gnt_clr;
    logic host_in_range;

    assign host_pend     = wr_req;
    assign clr_pend      = (clr_state_q == CLR_FILL);
    assign host_in_range = ({1'b0, wr_addr} < DEPTH_W);

    // Write arbitration for cycles the display leaves free.
    always_comb begin
        gnt_host = 1'b0;
        gnt_clr  = 1'b0;
        if (!disp_re) begin
            if (host_pend && clr_pend) begin
                gnt_host = ~rr_ptr_q;
                gnt_clr  = rr_ptr_q;
            end else begin
                gnt_host = host_pend;
                gnt_clr  = clr_pend;
            end
        end
    end

    // VRAM port mux; everything that touches memory is held off during reset.
    always_comb begin
        mem_en   = 1'b0;
        mem_we   = 1'b0;
        mem_addr = disp_addr;
        mem_din  = wr_data;
        wr_ack   = 1'b0;
        if (rstn) begin
            if (disp_re) begin
                mem_en = 1'b1;
            end else if (gnt_host) begin
                mem_en   = 1'b1;
                mem_we   = host_in_range;
                mem_addr = wr_addr;
                wr_ack   = 1'b1;
            end else if (gnt_clr) begin
                mem_en   = 1'b1;
                mem_we   = 1'b1;
                mem_addr = clr_cnt_q;
                mem_din  = clr_col_q;
            end
        end
    end

    // Round-robin pointer: after any granted write, favour the other source.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_host) begin
            rr_ptr_d = 1'b1;
        end else if (gnt_clr) begin
            rr_ptr_d = 1'b0;
        end
    end

    // Clear engine next-state: start only from idle, walk 0..DEPTH-1, then pulse done.
    always_comb begin
        clr_state_d = clr_state_q;
        clr_cnt_d   = clr_cnt_q;
        clr_col_d   = clr_col_q;
        case (clr_state_q)
            CLR_IDLE: begin
                if (clr_start) begin
                    clr_state_d = CLR_FILL;
                    clr_cnt_d   = '0;
                    clr_col_d   = clr_color;
                end
            end
            CLR_FILL: begin
                if (gnt_clr) begin
                    if (clr_cnt_q == LAST_ADDR) begin
                        clr_state_d = CLR_DONE;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
            CLR_DONE: begin
                clr_state_d = CLR_IDLE;
            end
            default: begin
                clr_state_d = CLR_IDLE;
            end
        endcase
    end

    // State registers for the clear engine and the arbiter pointer.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            clr_state_q <= CLR_IDLE;
            clr_cnt_q   <= '0;
            clr_col_q   <= '0;
            rr_ptr_q    <= 1'b0;
        end else begin
            clr_state_q <= clr_state_d;
            clr_cnt_q   <= clr_cnt_d;
            clr_col_q   <= clr_col_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Read-valid pipeline matching the VRAM read latency.
    always_ff @(posedge pclk or negedge rstn) begin
        if (!rstn) begin
            rv_q <= '0;
        end else begin
            rv_q[0] <= disp_re;
            for (int i = 1; i < RD_LAT; i++) begin
                rv_q[i] <= rv_q[i-1];
            end
        end
    end

    assign disp_rvalid = rv_q[RD_LAT-1];
    assign disp_rdata  = mem_dout;
    assign clr_busy    = (clr_state_q != CLR_IDLE);
    assign clr_done    = (clr_state_q == CLR_DONE);

endmodule
